// File: rtl/sd_spi_byte_if.sv
// Controller-facing byte handshake plus the four SPI pins of the SD card link.
// master = controller/card side, slave = the byte transceiver.
interface sd_spi_byte_if;
  logic       start;
  logic [7:0] din;
  logic       slow;
  logic       cs_en;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    output start, din, slow, cs_en, spi_miso,
    input  dout, busy, done, spi_cs, spi_sclk, spi_mosi
  );

  modport slave (
    input  start, din, slow, cs_en, spi_miso,
    output dout, busy, done, spi_cs, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte transceiver for the SD controller: one byte out on MOSI and
// one byte in from MISO per accepted start, SCLK divided from the system clock.
module sd_spi_byte #(
  parameter int SLOW_DIV = 125,
  parameter int FAST_DIV = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  sd_spi_byte_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] SLOW_LOAD = 8'(SLOW_DIV - 1);
  localparam logic [7:0] FAST_LOAD = 8'(FAST_DIV - 1);

  state_t     state_r, next_state_s;
  logic [7:0] tx_r, tx_s;
  logic [7:0] rx_r, rx_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] div_r, div_s;
  logic       slow_r, slow_s;
  logic       sclk_r, sclk_s;
  logic       mosi_r, mosi_s;
  logic       cs_r, cs_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic [7:0] dout_r, dout_s;

  logic       accept_s;
  logic       div_zero_s;
  logic [7:0] reload_s;

  assign accept_s   = bus.start && ((state_r == IDLE) || (state_r == DONE));
  assign div_zero_s = (div_r == 8'd0);
  assign reload_s   = slow_r ? SLOW_LOAD : FAST_LOAD;

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      tx_r    <= 8'h00;
      rx_r    <= 8'h00;
      bit_r   <= 3'd0;
      div_r   <= 8'd0;
      slow_r  <= 1'b0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b1;
      cs_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dout_r  <= 8'h00;
    end else begin
      state_r <= next_state_s;
      tx_r    <= tx_s;
      rx_r    <= rx_s;
      bit_r   <= bit_s;
      div_r   <= div_s;
      slow_r  <= slow_s;
      sclk_r  <= sclk_s;
      mosi_r  <= mosi_s;
      cs_r    <= cs_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dout_r  <= dout_s;
    end
  end

  // Next-state logic; DONE accepts a start just like IDLE so bytes can run back to back.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) next_state_s = LOW;
        else          next_state_s = IDLE;
      end
      LOW: begin
        if (div_zero_s) next_state_s = HIGH;
        else            next_state_s = LOW;
      end
      HIGH: begin
        if (!div_zero_s)          next_state_s = HIGH;
        else if (bit_r == 3'd7)   next_state_s = DONE;
        else                      next_state_s = LOW;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of datapath and output registers.
  always_comb begin
    tx_s   = tx_r;
    rx_s   = rx_r;
    bit_s  = bit_r;
    div_s  = div_r;
    slow_s = slow_r;
    sclk_s = sclk_r;
    mosi_s = mosi_r;
    cs_s   = cs_r;
    dout_s = dout_r;
    busy_s = (next_state_s == LOW) || (next_state_s == HIGH);
    done_s = (next_state_s == DONE);
    case (state_r)
      IDLE, DONE: begin
        cs_s   = ~bus.cs_en;
        sclk_s = 1'b0;
        if (accept_s) begin
          tx_s   = {bus.din[6:0], 1'b1};
          mosi_s = bus.din[7];
          slow_s = bus.slow;
          bit_s  = 3'd0;
          div_s  = bus.slow ? SLOW_LOAD : FAST_LOAD;
        end else begin
          mosi_s = 1'b1;
        end
      end
      LOW: begin
        if (div_zero_s) begin
          sclk_s = 1'b1;
          rx_s   = {rx_r[6:0], bus.spi_miso};
          div_s  = reload_s;
        end else begin
          div_s = div_r - 8'd1;
        end
      end
      HIGH: begin
        if (div_zero_s) begin
          sclk_s = 1'b0;
          // MOSI only moves here, on the falling SCLK edge.
          if (bit_r == 3'd7) begin
            dout_s = rx_r;
          end else begin
            mosi_s = tx_r[7];
            tx_s   = {tx_r[6:0], 1'b1};
            bit_s  = bit_r + 3'd1;
            div_s  = reload_s;
          end
        end else begin
          div_s = div_r - 8'd1;
        end
      end
      default: begin
        sclk_s = 1'b0;
        mosi_s = 1'b1;
        cs_s   = 1'b1;
      end
    endcase
  end

  assign bus.dout     = dout_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.spi_cs   = cs_r;
  assign bus.spi_sclk = sclk_r;
  assign bus.spi_mosi = mosi_r;

endmodule

// File: tb/tb_sd_spi_byte.sv
// Directed bench for sd_spi_byte: vector table plus hand-written multi-cycle sequences,
// with a card model that shifts a byte out on MISO MSB first.
module tb_sd_spi_byte;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  sd_spi_byte_if bus();

  sd_spi_byte #(.SLOW_DIV(125), .FAST_DIV(1)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #20 clock = ~clock;

  typedef struct {
    logic [7:0] din;
    logic [7:0] card;
    logic       slow;
    logic       cs_en;
    logic [7:0] exp_dout;
    logic       exp_cs;
    int         exp_lat;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_total = 0;
  int rise_base = 0;
  int done_cnt = 0;
  int cs_bad = 0;
  int cs_base = 0;
  int t0 = 0;
  int last_rise = 0;
  int period = 0;
  int high_len = 0;
  logic       exp_cs = 1'b1;
  logic [7:0] card_byte = 8'hFF;
  logic [7:0] mosi_cap = 8'h00;
  logic [2:0] card_idx;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) if (bus.done === 1'b1) done_cnt = done_cnt + 1;

  always @(posedge bus.spi_sclk) begin
    rise_total = rise_total + 1;
    mosi_cap   = {mosi_cap[6:0], bus.spi_mosi};
    if (bus.spi_cs !== exp_cs) cs_bad = cs_bad + 1;
    period     = cyc - last_rise;
    last_rise  = cyc;
  end

  always @(negedge bus.spi_sclk) high_len = cyc - last_rise;

  // Card drives the next bit as soon as the DUT has sampled the current one.
  assign card_idx     = 3'd7 - 3'(rise_total - rise_base);
  assign bus.spi_miso = card_byte[card_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic [7:0] c, input logic s, input logic ce);
    bus.din   = d;
    bus.slow  = s;
    bus.cs_en = ce;
    card_byte = c;
    rise_base = rise_total;
    cs_base   = cs_bad;
    exp_cs    = ~ce;
    bus.start = 1'b1;
    t0        = cyc;
  endtask

  task automatic wait_done(output int at, input int limit);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL done_timeout: got no done, expected one within %0d cycles", limit);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int at;
    @(negedge clock);
    launch(v.din, v.card, v.slow, v.cs_en);
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(at, 3000);
    if (at >= 0) begin
      chk({tag, "_latency"}, at - t0, v.exp_lat);
      chk({tag, "_dout"}, bus.dout, v.exp_dout);
      chk({tag, "_mosi"}, mosi_cap, v.din);
      chk({tag, "_rises"}, rise_total - rise_base, 8);
      chk({tag, "_cs"}, cs_bad - cs_base, 0);
      chk({tag, "_cs_level"}, bus.spi_cs, v.exp_cs);
      if (v.slow) begin
        chk({tag, "_sclk_period"}, period, 250);
        chk({tag, "_sclk_high"}, high_len, 125);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int at, at1, at2, d0, r0, cb0;

    vecs[0] = '{din: 8'hA5, card: 8'h3C, slow: 1'b0, cs_en: 1'b1, exp_dout: 8'h3C, exp_cs: 1'b0, exp_lat: 17};
    vecs[1] = '{din: 8'h00, card: 8'hFF, slow: 1'b0, cs_en: 1'b1, exp_dout: 8'hFF, exp_cs: 1'b0, exp_lat: 17};
    vecs[2] = '{din: 8'hFF, card: 8'h00, slow: 1'b0, cs_en: 1'b1, exp_dout: 8'h00, exp_cs: 1'b0, exp_lat: 17};
    vecs[3] = '{din: 8'h5A, card: 8'hC3, slow: 1'b0, cs_en: 1'b0, exp_dout: 8'hC3, exp_cs: 1'b1, exp_lat: 17};
    vecs[4] = '{din: 8'h81, card: 8'h7E, slow: 1'b1, cs_en: 1'b1, exp_dout: 8'h7E, exp_cs: 1'b0, exp_lat: 2001};

    bus.start = 1'b0;
    bus.din   = 8'h00;
    bus.slow  = 1'b0;
    bus.cs_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_cs", bus.spi_cs, 1'b1);
    chk("reset_sclk", bus.spi_sclk, 1'b0);
    chk("reset_mosi", bus.spi_mosi, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_dout", bus.dout, 8'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_cs_tracks", bus.spi_cs, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second start lands in the done cycle of the first.
    @(negedge clock);
    launch(8'h3C, 8'h96, 1'b0, 1'b1);
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(at1, 100);
    chk("b2b_first_dout", bus.dout, 8'h96);
    launch(8'hFF, 8'h4D, 1'b0, 1'b1);
    @(negedge clock);
    bus.start = 1'b0;
    chk("b2b_no_idle_busy", bus.busy, 1'b1);
    wait_done(at2, 100);
    chk("b2b_done_gap", at2 - at1, 17);
    chk("b2b_second_dout", bus.dout, 8'h4D);
    chk("b2b_second_mosi", mosi_cap, 8'hFF);

    // Start pulsed while busy must be dropped.
    @(negedge clock);
    launch(8'h11, 8'h22, 1'b0, 1'b1);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    bus.din   = 8'h00;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(at, 100);
    chk("ignored_dout", bus.dout, 8'h22);
    chk("ignored_mosi", mosi_cap, 8'h11);
    chk("ignored_latency", at - t0, 17);
    @(negedge clock);
    d0 = done_cnt;
    repeat (40) @(negedge clock);
    chk("ignored_no_extra_done", done_cnt - d0, 0);

    // Ten dummy bytes with CS deasserted: 80 SCLK clocks.
    d0  = done_cnt;
    r0  = rise_total;
    cb0 = cs_bad;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      launch(8'hFF, 8'hFF, 1'b0, 1'b0);
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(at, 100);
    end
    @(negedge clock);
    chk("dummy_rises", rise_total - r0, 80);
    chk("dummy_cs_high", cs_bad - cb0, 0);
    chk("dummy_done_count", done_cnt - d0, 10);

    // Reset dropped after three bits of a transfer.
    @(negedge clock);
    launch(8'hC3, 8'hA5, 1'b0, 1'b1);
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rise_total - rise_base >= 3) break;
      @(negedge clock);
    end
    chk("midreset_reached_bit3", rise_total - rise_base, 3);
    d0 = done_cnt;
    #5;
    reset_n = 1'b0;
    #1;
    chk("midreset_cs", bus.spi_cs, 1'b1);
    chk("midreset_sclk", bus.spi_sclk, 1'b0);
    chk("midreset_mosi", bus.spi_mosi, 1'b1);
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_done", bus.done, 1'b0);
    chk("midreset_dout", bus.dout, 8'h00);
    repeat (5) @(negedge clock);
    chk("midreset_no_done", done_cnt - d0, 0);
    reset_n = 1'b1;
    run_vec('{din: 8'h96, card: 8'h69, slow: 1'b0, cs_en: 1'b1, exp_dout: 8'h69, exp_cs: 1'b0, exp_lat: 17},
            "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
